// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
// IF-stage sequencer for the five-stage RISC-V pipeline. Owns the program
// counter, steers the shared next-PC adder, issues instruction-memory
// requests, applies EX-stage redirects (branch / jal / jalr) and hazard-unit
// stalls, and raises the IF/ID and ID/EX flushes.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   stall               load-use stall request from the hazard unit
//   ex_valid            EX stage holds a valid instruction
//   ex_branch_taken     conditional branch in EX resolved taken
//   ex_jal, ex_jalr     jump in EX
//   ex_pc               PC of the EX instruction
//   npc_result          sum returned by the next-PC adder
//   npc_base            pc operand for the next-PC adder
//   PCASrc              adder B operand: 1 = immediate, 0 = constant 4
//   PCBSrc              adder A operand: 1 = ReadData1, 0 = npc_base
//   pc                  current fetch PC
//   imem_req/imem_addr  instruction fetch request and address (= pc)
//   imem_ready          memory accepts and returns data this cycle
//   if_valid            fetched word is valid for IF/ID this cycle
//   flush_if_id/id_ex   clear the IF/ID and ID/EX pipeline registers
//   misalign_err        sticky misaligned-target flag
//   dbg_state           FSM state (0 IDLE, 1 FETCH, 2 HOLD, 3 DRAIN)
//
// Handshake: a fetch transfers on a cycle where imem_req and imem_ready are
// both high. Once imem_req is raised it stays high with imem_addr stable
// until that transfer; a request is never withdrawn except by reset.
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_branch_taken,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] npc_result,
  output logic [31:0] npc_base,
  output logic        PCASrc,
  output logic        PCBSrc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        if_valid,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        misalign_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        mis_q, mis_d;

  logic        redirect;
  logic        take;
  logic [31:0] target_raw;
  logic [31:0] target_al;

  assign redirect = ex_valid & (ex_branch_taken | ex_jal | ex_jalr);
  // Redirects are ignored while IDLE: the pipeline has not started yet.
  assign take     = redirect & (state_q != S_IDLE);

  // jalr clears bit 0 of its sum; the PC itself is always word aligned.
  assign target_raw = {npc_result[31:1], npc_result[0] & ~ex_jalr};
  assign target_al  = {target_raw[31:2], 2'b00};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0000_0000;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    mis_d   = mis_q | (take & (target_raw[1:0] != 2'b00));

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (redirect) begin
          if (imem_ready) begin
            // Response in flight belongs to the wrong path; drop it.
            pc_d = target_al;
          end else begin
            // Request cannot be withdrawn: park the target until it completes.
            tgt_d   = target_al;
            state_d = S_DRAIN;
          end
        end else if (imem_ready) begin
          if (stall) begin
            state_d = S_HOLD;
          end else begin
            pc_d = npc_result;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = target_al;
          state_d = S_FETCH;
        end else if (!stall) begin
          state_d = S_FETCH;
        end
      end

      S_DRAIN: begin
        if (redirect) begin
          tgt_d = target_al;
        end
        if (imem_ready) begin
          pc_d    = redirect ? target_al : tgt_q;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    npc_base    = pc_q;
    PCASrc      = 1'b0;
    PCBSrc      = 1'b0;
    imem_req    = 1'b0;
    if_valid    = 1'b0;
    flush_if_id = take;
    flush_id_ex = take;

    if (take) begin
      npc_base = ex_pc;
      PCASrc   = 1'b1;
      PCBSrc   = ex_jalr;
    end

    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if_valid = imem_ready & ~stall & ~redirect;
      end
      S_DRAIN: begin
        imem_req = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign pc           = pc_q;
  assign imem_addr    = pc_q;
  assign misalign_err = mis_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Directed scenarios followed by randomized traffic. The bench plays the
// next-PC adder and keeps a transaction-level model of the fetch unit
// (current PC, whether a dropped fetch is waiting for stall release, whether
// a redirect is waiting for an outstanding request). Fetched addresses the
// model expects are queued and matched against if_valid beats.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [1:0]  IDLE_CODE = 2'd0;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT signals
  logic        stall, ex_valid, ex_branch_taken, ex_jal, ex_jalr;
  logic [31:0] ex_pc, npc_result, npc_base, pc, imem_addr;
  logic        PCASrc, PCBSrc, imem_req, imem_ready, if_valid;
  logic        flush_if_id, flush_id_ex, misalign_err;
  logic [1:0]  dbg_state;

  pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
    .ex_branch_taken(ex_branch_taken), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_pc(ex_pc), .npc_result(npc_result), .npc_base(npc_base),
    .PCASrc(PCASrc), .PCBSrc(PCBSrc), .pc(pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .if_valid(if_valid),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .misalign_err(misalign_err), .dbg_state(dbg_state)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model
  bit          m_started;
  bit          m_dropped;
  bit          m_draining;
  bit          m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_drain_tgt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started   = 1'b0;
    m_dropped   = 1'b0;
    m_draining  = 1'b0;
    m_mis       = 1'b0;
    m_pc        = RESET_PC;
    m_drain_tgt = 32'h0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, act as the adder, check at the negedge,
  // advance the model, and return #1 after the next rising edge.
  task automatic step(input bit s, input bit ev, input bit br, input bit jl, input bit jr,
                      input logic [31:0] epc, input logic [31:0] r1, input logic [31:0] im,
                      input bit rdy);
    bit          redir, e_req, e_valid, e_flush, e_a, e_b;
    logic [31:0] e_base, raw, tgt;
    stall = s; ex_valid = ev; ex_branch_taken = br; ex_jal = jl; ex_jalr = jr;
    ex_pc = epc; imem_ready = rdy;
    redir = ev && (br || jl || jr);
    if (m_started && redir) npc_result = (jr ? r1 : epc) + im;
    else                    npc_result = m_pc + 32'd4;

    @(negedge clk);
    if (rst_n) begin
      if (!m_started) begin
        e_req = 0; e_valid = 0; e_flush = 0; e_a = 0; e_b = 0; e_base = m_pc;
      end else begin
        e_flush = redir;
        e_a     = redir;
        e_b     = redir && jr;
        e_base  = redir ? epc : m_pc;
        e_req   = !m_dropped;
        e_valid = e_req && !m_draining && rdy && !s && !redir;
      end
      check_eq("imem_req", imem_req, e_req);
      check_eq("imem_addr", imem_addr, m_pc);
      check_eq("pc", pc, m_pc);
      check_eq("if_valid", if_valid, e_valid);
      check_eq("flush_if_id", flush_if_id, e_flush);
      check_eq("flush_id_ex", flush_id_ex, e_flush);
      check_eq("PCASrc", PCASrc, e_a);
      check_eq("PCBSrc", PCBSrc, e_b);
      check_eq("npc_base", npc_base, e_base);
      check_eq("misalign_err", misalign_err, m_mis);

      if (e_valid) exp_q.push_back(m_pc);
      if (if_valid === 1'b1) begin
        if (exp_q.size() == 0) check_eq("sb_unexpected", if_valid, 0);
        else                   check_eq("sb_addr", imem_addr, exp_q.pop_front());
      end

      // Advance model
      if (!m_started) begin
        m_started = 1'b1;
      end else begin
        raw = npc_result;
        if (redir && jr) raw[0] = 1'b0;
        tgt = {raw[31:2], 2'b00};
        if (redir && raw[1:0] != 2'b00) m_mis = 1'b1;
        if (m_draining) begin
          if (redir) m_drain_tgt = tgt;
          if (rdy) begin
            m_pc = m_drain_tgt;
            m_draining = 1'b0;
          end
        end else if (m_dropped) begin
          if (redir) begin
            m_pc = tgt;
            m_dropped = 1'b0;
          end else if (!s) begin
            m_dropped = 1'b0;
          end
        end else if (redir) begin
          if (rdy) m_pc = tgt;
          else begin
            m_draining  = 1'b1;
            m_drain_tgt = tgt;
          end
        end else if (rdy) begin
          if (s) m_dropped = 1'b1;
          else   m_pc = m_pc + 32'd4;
        end
      end
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input bit rdy);
    step(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, rdy);
  endtask

  initial begin
    logic [31:0] r_epc, r_r1, r_im;
    rst_n = 1'b0;
    model_reset();
    idle_step(0);
    idle_step(0);
    rst_n = 1'b1;

    // Reset state, then free run
    check_eq("reset_addr", imem_addr, RESET_PC);
    check_eq("reset_req", imem_req, 0);
    check_eq("reset_state", dbg_state, IDLE_CODE);
    idle_step(1);
    check_eq("after_idle_req", imem_req, 1);
    idle_step(1);
    check_eq("run_addr4", imem_addr, 32'h4);
    idle_step(1);
    check_eq("run_addr8", imem_addr, 32'h8);

    // Stall two cycles at pc 0x8, then refetch
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("hold_req", imem_req, 0);
    check_eq("hold_addr", imem_addr, 32'h8);
    idle_step(1);
    check_eq("refetch_addr", imem_addr, 32'h8);
    idle_step(1);
    check_eq("after_refetch", imem_addr, 32'hC);
    idle_step(1);
    check_eq("addr_10", imem_addr, 32'h10);

    // Taken branch from 0x10 with offset 0x20
    step(0, 1, 1, 0, 0, 32'h10, 32'h0, 32'h20, 1);
    check_eq("branch_addr", imem_addr, 32'h30);

    // jalr to 0x103 while the fetch is pending
    step(0, 1, 0, 0, 1, 32'h30, 32'h100, 32'h3, 0);
    check_eq("drain_req", imem_req, 1);
    check_eq("drain_addr", imem_addr, 32'h30);
    check_eq("drain_mis", misalign_err, 1);
    idle_step(0);
    check_eq("drain_hold_addr", imem_addr, 32'h30);
    idle_step(1);
    check_eq("jalr_addr", imem_addr, 32'h100);
    check_eq("jalr_mis", misalign_err, 1);

    // Wrap-around from 0xFFFF_FFFC
    step(0, 1, 0, 1, 0, 32'hFFFF_FFF0, 32'h0, 32'hC, 1);
    check_eq("top_addr", imem_addr, 32'hFFFF_FFFC);
    idle_step(1);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Reset in the middle of DRAIN
    step(0, 1, 1, 0, 0, 32'h40, 32'h0, 32'h8, 0);
    check_eq("pre_reset_req", imem_req, 1);
    rst_n = 1'b0;
    idle_step(0);
    rst_n = 1'b1;
    check_eq("rst_drain_addr", imem_addr, RESET_PC);
    check_eq("rst_drain_req", imem_req, 0);
    check_eq("rst_drain_mis", misalign_err, 0);
    check_eq("rst_drain_state", dbg_state, IDLE_CODE);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      r_epc = $urandom & 32'hFFFF_FFFC;
      r_r1  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) r_r1 = r_r1 + 32'($urandom_range(1, 3));
      r_im  = (32'($urandom_range(0, 255)) << 2) - 32'd512;
      if ($urandom_range(0, 15) == 0) r_im = r_im + 32'($urandom_range(1, 3));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0, r_epc, r_r1, r_im,
           $urandom_range(0, 3) != 0);
    end
    rst_n = 1'b1;

    check_eq("sb_leftover", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequencer for the next-PC adder and the program-counter register in the IF stage of the five-stage RISC-V pipeline. It owns the PC register and drives the adder's base, PCASrc and PCBSrc selects. It issues instruction-memory requests with a req/ready handshake. It applies EX-stage redirects (branch, jal, jalr) and hazard-unit stalls, and raises pipeline flushes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active low
stall  in  1  hazard-unit stall request (load-use)
ex_valid  in  1  EX stage holds a valid instruction
ex_branch_taken  in  1  conditional branch in EX resolved taken
ex_jal  in  1  jal in EX
ex_jalr  in  1  jalr in EX
ex_pc  in  32  PC of the EX instruction
npc_result  in  32  sum returned by the next-PC adder
npc_base  out  32  pc input to the next-PC adder
PCASrc  out  1  1 selects immediate offset, 0 selects constant 4
PCBSrc  out  1  1 selects ReadData1 base, 0 selects npc_base
pc  out  32  current fetch PC
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address, equals pc
imem_ready  in  1  memory accepts and returns data this cycle
if_valid  out  1  fetched word is valid for IF/ID this cycle
flush_if_id  out  1  clear IF/ID register
flush_id_ex  out  1  clear ID/EX register
misalign_err  out  1  sticky misaligned-target flag

Behaviour:
- States: IDLE, FETCH, HOLD, DRAIN.
- Reset (rst_n=0 at a rising edge) sets pc=RESET_PC, state=IDLE, misalign_err=0, latched target=0. While in IDLE: imem_req=0, if_valid=0, flushes=0, PCASrc=PCBSrc=0, npc_base=pc.
- IDLE goes to FETCH unconditionally on the next edge.
- redirect = ex_valid & (ex_branch_taken | ex_jal | ex_jalr). Redirect has priority over stall.
- Adder selects (combinational):
  - redirect with ex_jalr: npc_base=ex_pc, PCASrc=1, PCBSrc=1.
  - redirect with branch or jal: npc_base=ex_pc, PCASrc=1, PCBSrc=0.
  - otherwise: npc_base=pc, PCASrc=0, PCBSrc=0, so npc_result=pc+4.
  - If ex_jalr is asserted together with ex_jal or ex_branch_taken, ex_jalr wins.
- target = npc_result, with bit0 cleared when ex_jalr. If target[1:0]!=0, misalign_err is set and stays set until reset. The PC loads {target[31:2],2'b00}.
- flush_if_id and flush_id_ex = redirect, combinational, in any state except IDLE.
- Sequential pc arithmetic is modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
- FETCH:
  - imem_req=1 and imem_addr=pc. Address stays stable until imem_ready.
  - if_valid = imem_ready & ~stall & ~redirect.
  - redirect & imem_ready: response discarded, pc<=target, stay in FETCH.
  - redirect & ~imem_ready: latch target, go to DRAIN. The outstanding request is never withdrawn.
  - imem_ready & stall (no redirect): response dropped, pc held, go to HOLD.
  - imem_ready & ~stall: pc<=pc+4 (npc_result), stay in FETCH. Latency is one fetch per cycle with zero-wait memory.
  - ~imem_ready with no redirect: hold everything; stall is irrelevant here.
- HOLD:
  - imem_req=0, if_valid=0.
  - redirect: pc<=target, go to FETCH.
  - else ~stall: go to FETCH, refetching the same pc.
  - else remain in HOLD.
- DRAIN:
  - imem_req=1 with the old address, if_valid=0.
  - A new redirect overwrites the latched target.
  - On imem_ready: pc<=latched target (or the new target if a redirect arrives that cycle), go to FETCH.
- Reset asserted in any state, including DRAIN, overrides everything. The outstanding request is abandoned.

Test Plan:
- Reset then free run: RESET_PC=0, imem_ready=1 -> IDLE one cycle, then imem_addr 0,4,8,C on consecutive cycles, if_valid=1 each cycle, PCASrc=PCBSrc=0.
- Stall: stall=1 for 2 cycles while pc=0x8 with ready=1 -> if_valid=0, HOLD, imem_req=0. After release, addr 0x8 is refetched, then 0xC.
- Branch redirect with ready: ex_pc=0x10, model npc_result=0x10+0x20 -> PCASrc=1, PCBSrc=0, npc_base=0x10, flushes pulse 1 cycle, next imem_addr=0x30.
- jalr with pending fetch: ready=0, ex_jalr=1, npc_result=0x103 -> DRAIN, old addr held. When ready rises, no if_valid, then imem_addr=0x100 and misalign_err=1.
- Wrap-around: pc=0xFFFF_FFFC, ready=1 -> next addr 0x0000_0000.
- Reset mid-DRAIN: rst_n=0 for 1 cycle -> pc=RESET_PC, imem_req=0, misalign_err=0, state IDLE.
